sprite_palette_engine: RTL and testbench

Runtime-writable, multi-bank sprite palette. It maps a per-pixel colour index to a 12-bit (default) RGB value through a 2-stage registered pipeline and flags the transparency key. It replaces the fixed per-sprite constant palettes. The sprite loader writes banks after reset, and the VGA colour mapper reads one lookup per pixel, with bank select used for animation frames and player variants.

---
 rtl/sprite_palette_pkg.sv | 29 ++
 rtl/palette_ram.sv | 29 ++
 rtl/sprite_palette_engine.sv | 156 +++++++++++++++
 tb/tb_sprite_palette_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
// Shared types, defaults and helpers for the sprite palette engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_palette_pkg;

  localparam int DEF_INDEX_W   = 9;
  localparam int DEF_CH_W      = 4;
  localparam int DEF_PAL_SEL_W = 1;

  // Magenta key marks transparent sprite pixels; also the power-up fill.
  localparam logic [3*DEF_CH_W-1:0] DEF_TRANSP_KEY = 12'hF0F;

  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pal_state_e;

  // Total words across all banks.
  function automatic int pal_depth(input int index_w, input int sel_w);
    return (1 << sel_w) * (1 << index_w);
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette storage: one write port, one registered read port.
// Latency: read data 1 cycle after the address; read-first on same-address collision.
// Backpressure: none, accepts a read and a write every cycle.
module palette_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_dat_q;

  // Write and read in one block so the read samples the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
    rd_dat_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/sprite_palette_engine.sv
// Multi-bank runtime-writable sprite palette: colour index -> RGB plus transparency flag.
// Latency: 2 cycles pix_valid_i -> out_valid_o; fills all banks with the key for DEPTH cycles after reset.
// Backpressure: lookups never stall; writes are refused (wr_ready_o=0) until the fill ends.
// Optional brightness fade on the output is enabled by defining PALETTE_FADE_EN.
module sprite_palette_engine
  import sprite_palette_pkg::*;
#(
  parameter int                INDEX_W    = DEF_INDEX_W,
  parameter int                CH_W       = DEF_CH_W,
  parameter int                PAL_SEL_W  = DEF_PAL_SEL_W,
  parameter logic [3*CH_W-1:0] TRANSP_KEY = DEF_TRANSP_KEY
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid_i,
  input  logic [INDEX_W-1:0]   pix_index_i,
  input  logic [PAL_SEL_W-1:0] pal_sel_i,
  output logic                 out_valid_o,
  output logic [CH_W-1:0]      red_o,
  output logic [CH_W-1:0]      green_o,
  output logic [CH_W-1:0]      blue_o,
  output logic                 transparent_o,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [PAL_SEL_W-1:0] wr_pal_i,
  input  logic [INDEX_W-1:0]   wr_index_i,
  input  logic [3*CH_W-1:0]    wr_color_i,
`ifdef PALETTE_FADE_EN
  input  logic [3:0]           fade_lvl_i,
`endif
  output logic                 init_done_o
);

  localparam int                ADDR_W    = PAL_SEL_W + INDEX_W;
  localparam int                DEPTH     = pal_depth(INDEX_W, PAL_SEL_W);
  localparam int                COL_W     = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  pal_state_e        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [COL_W-1:0]  ram_wdat;
  logic [COL_W-1:0]  rd_dat;

  logic              s1_vld_q, s1_vld_d;
  logic              s2_vld_q;
  logic [COL_W-1:0]  colour_q, colour_d;
  logic              transp_q, transp_d;

  // State register and fill counter; reset restarts the fill from address 0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state and write-port steering: fill owns the port in INIT, the loader in RUN.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ram_we     = 1'b0;
    ram_waddr  = {wr_pal_i, wr_index_i};
    ram_wdat   = wr_color_i;
    case (state_q)
      INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_wdat   = TRANSP_KEY;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ram_we = wr_valid_i;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  assign wr_ready_o  = (state_q == RUN);
  assign init_done_o = (state_q == RUN);

  // Stage 1 data register lives inside the RAM (registered read).
  palette_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (COL_W)
  ) u_ram (
    .clk_i     (Clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_dat_i  (ram_wdat),
    .rd_addr_i ({pal_sel_i, pix_index_i}),
    .rd_dat_o  (rd_dat)
  );

`ifdef PALETTE_FADE_EN
  // Scale one channel by (lvl+1)/16; lvl=15 is identity.
  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch,
                                              input logic [3:0]      lvl);
    logic [CH_W+3:0] prod;
    prod = (CH_W+4)'(ch) * (CH_W+4)'({1'b0, lvl} + 5'd1);
    return prod[CH_W+3:4];
  endfunction

  // Stage 2 colour with fade applied; transparency still judged on the raw colour.
  always_comb begin
    colour_d = {fade_ch(rd_dat[3*CH_W-1:2*CH_W], fade_lvl_i),
                fade_ch(rd_dat[2*CH_W-1:CH_W],   fade_lvl_i),
                fade_ch(rd_dat[CH_W-1:0],        fade_lvl_i)};
  end
`else
  // Stage 2 colour is the raw palette entry.
  always_comb begin
    colour_d = rd_dat;
  end
`endif

  // Lookup requests are dropped while the fill is running.
  always_comb begin
    s1_vld_d = pix_valid_i && (state_q == RUN);
    transp_d = (rd_dat == TRANSP_KEY);
  end

  // Pipeline valids and stage-2 result; outputs hold between valid lookups.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      colour_q <= '0;
      transp_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        colour_q <= colour_d;
        transp_q <= transp_d;
      end
    end
  end

  assign out_valid_o   = s2_vld_q;
  assign red_o         = colour_q[3*CH_W-1:2*CH_W];
  assign green_o       = colour_q[2*CH_W-1:CH_W];
  assign blue_o        = colour_q[CH_W-1:0];
  assign transparent_o = transp_q;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Directed bench for sprite_palette_engine at default parameters.
// Latency: checks the 2-cycle lookup path and 1024-cycle fill.
// Backpressure: exercises wr_ready_o gating during the fill.
module tb_sprite_palette_engine;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid_i;
  logic [8:0]  pix_index_i;
  logic [0:0]  pal_sel_i;
  logic        out_valid_o;
  logic [3:0]  red_o, green_o, blue_o;
  logic        transparent_o;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [0:0]  wr_pal_i;
  logic [8:0]  wr_index_i;
  logic [11:0] wr_color_i;
  logic        init_done_o;
`ifdef PALETTE_FADE_EN
  logic [3:0]  fade_lvl_i;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_col [8];

  sprite_palette_engine dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .pix_valid_i   (pix_valid_i),
    .pix_index_i   (pix_index_i),
    .pal_sel_i     (pal_sel_i),
    .out_valid_o   (out_valid_o),
    .red_o         (red_o),
    .green_o       (green_o),
    .blue_o        (blue_o),
    .transparent_o (transparent_o),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_pal_i      (wr_pal_i),
    .wr_index_i    (wr_index_i),
    .wr_color_i    (wr_color_i),
`ifdef PALETTE_FADE_EN
    .fade_lvl_i    (fade_lvl_i),
`endif
    .init_done_o   (init_done_o)
  );

  initial begin
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold pix_valid_i high through the fill and count cycles until init_done_o.
  task automatic wait_init(input string tag);
    int   cnt;
    logic bad;
    cnt = 0;
    bad = 1'b0;
    pix_valid_i = 1'b1;
    while (!init_done_o && cnt < 2000) begin
      tick();
      cnt++;
      if (!init_done_o && (out_valid_o || wr_ready_o)) bad = 1'b1;
    end
    pix_valid_i = 1'b0;
    check({tag, "_cycles"}, cnt, 1024);
    check({tag, "_quiet"}, {31'd0, bad}, 0);
  endtask

  task automatic lookup(input logic [0:0] sel, input logic [8:0] idx,
                        input logic [11:0] col, input logic tr, input string tag);
    pix_valid_i = 1'b1;
    pal_sel_i   = sel;
    pix_index_i = idx;
    tick();
    pix_valid_i = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid_o}, 0);
    tick();
    check({tag, "_vld"}, {31'd0, out_valid_o}, 1);
    check({tag, "_rgb"}, {20'd0, red_o, green_o, blue_o}, {20'd0, col});
    check({tag, "_tr"}, {31'd0, transparent_o}, {31'd0, tr});
  endtask

  task automatic write_entry(input logic [0:0] pal, input logic [8:0] idx, input logic [11:0] col);
    check("wr_ready", {31'd0, wr_ready_o}, 1);
    wr_valid_i = 1'b1;
    wr_pal_i   = pal;
    wr_index_i = idx;
    wr_color_i = col;
    tick();
    wr_valid_i = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    pix_valid_i = 1'b0;
    pix_index_i = '0;
    pal_sel_i   = '0;
    wr_valid_i  = 1'b0;
    wr_pal_i    = '0;
    wr_index_i  = '0;
    wr_color_i  = '0;
`ifdef PALETTE_FADE_EN
    fade_lvl_i  = 4'd15;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_vld", {31'd0, out_valid_o}, 0);
    check("rst_rgb", {20'd0, red_o, green_o, blue_o}, 0);
    check("rst_tr", {31'd0, transparent_o}, 0);
    check("rst_wrdy", {31'd0, wr_ready_o}, 0);
    check("rst_done", {31'd0, init_done_o}, 0);

    // Fill: 1024 cycles, no writes accepted, lookups ignored
    Reset = 1'b0;
    wait_init("init");

    // Untouched entry in the top of bank 1 reads the key
    lookup(1'b1, 9'h1FF, 12'hF0F, 1'b1, "b1_1ff");

    // Same-cycle write+lookup is read-first; next-cycle lookup sees the new value
    check("wr_ready_run", {31'd0, wr_ready_o}, 1);
    wr_valid_i  = 1'b1;
    wr_pal_i    = 1'b0;
    wr_index_i  = 9'h005;
    wr_color_i  = 12'h3A7;
    pix_valid_i = 1'b1;
    pal_sel_i   = 1'b0;
    pix_index_i = 9'h005;
    tick();
    wr_valid_i = 1'b0;
    tick();
    pix_valid_i = 1'b0;
    check("rf_vld", {31'd0, out_valid_o}, 1);
    check("rf_rgb", {20'd0, red_o, green_o, blue_o}, 32'hF0F);
    check("rf_tr", {31'd0, transparent_o}, 1);
    tick();
    check("new_vld", {31'd0, out_valid_o}, 1);
    check("new_rgb", {20'd0, red_o, green_o, blue_o}, 32'h3A7);
    check("new_tr", {31'd0, transparent_o}, 0);
    tick();
    check("hold_vld", {31'd0, out_valid_o}, 0);
    check("hold_rgb", {20'd0, red_o, green_o, blue_o}, 32'h3A7);

    // Unique entries 0..7, bank alternating, then back-to-back lookups
    for (int i = 0; i < 8; i++) begin
      exp_col[i] = 12'h120 + 12'(i) * 12'h101;
      write_entry(1'(i), 9'(i), exp_col[i]);
    end
    for (int c = 0; c <= 8; c++) begin
      if (c < 8) begin
        pix_valid_i = 1'b1;
        pal_sel_i   = 1'(c);
        pix_index_i = 9'(c);
      end else begin
        pix_valid_i = 1'b0;
      end
      tick();
      if (c >= 1) begin
        check($sformatf("burst%0d_vld", c - 1), {31'd0, out_valid_o}, 1);
        check($sformatf("burst%0d_rgb", c - 1), {20'd0, red_o, green_o, blue_o}, {20'd0, exp_col[c-1]});
        check($sformatf("burst%0d_tr", c - 1), {31'd0, transparent_o}, 0);
      end
    end
    tick();
    check("burst_end_vld", {31'd0, out_valid_o}, 0);

    // Reset in RUN mid-stream flushes the pipe and refills every bank
    pix_valid_i = 1'b1;
    pal_sel_i   = 1'b0;
    pix_index_i = 9'h005;
    tick();
    tick();
    check("pre_rst_vld", {31'd0, out_valid_o}, 1);
    Reset = 1'b1;
    tick();
    check("mid_rst_vld", {31'd0, out_valid_o}, 0);
    check("mid_rst_done", {31'd0, init_done_o}, 0);
    check("mid_rst_wrdy", {31'd0, wr_ready_o}, 0);
    check("mid_rst_rgb", {20'd0, red_o, green_o, blue_o}, 0);
    Reset = 1'b0;
    wait_init("reinit");
    lookup(1'b0, 9'h005, 12'hF0F, 1'b1, "refill_005");
    lookup(1'b1, 9'h003, 12'hF0F, 1'b1, "refill_b1_003");

`ifdef PALETTE_FADE_EN
    write_entry(1'b0, 9'h010, 12'hF84);
    fade_lvl_i = 4'd7;
    lookup(1'b0, 9'h010, 12'h742, 1'b0, "fade7");
    fade_lvl_i = 4'd0;
    lookup(1'b0, 9'h011, 12'h000, 1'b1, "fade0_key");
    fade_lvl_i = 4'd15;
    lookup(1'b0, 9'h010, 12'hF84, 1'b0, "fade15");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
